// File: rtl/proc_fetch_pkg.sv
// ============================================================================
// proc_fetch_pkg : shared types and constants for the instruction prefetch path
// Rev 1.0
// ============================================================================
`default_nettype none

package proc_fetch_pkg;

    localparam int          FETCH_DEPTH = 4;
    localparam logic [31:0] NOP_INSN    = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous {pc, insn} FIFO with push, pop, flush, occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import proc_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [ENTRY_W-1:0]           push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [ENTRY_W-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Flush wins over push and pop; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, insn: NOP_INSN};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= fetch_entry_t'(push_data_i);
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/imem_prefetch.sv
// ============================================================================
// imem_prefetch : fetch PC, credit-limited imem reads, redirect flush, decode handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_prefetch
    import proc_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic               req_valid_q, req_valid_d;
    logic [CW-1:0]      w_count;
    logic               w_issue;
    logic               w_pop;
    logic               w_push;
    fetch_entry_t       w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    fetch_entry_t       w_head_entry;

    // Credit ignores a same-cycle pop so insn_ready never reaches the imem address.
    always_comb begin
        address_imem = redirect ? redirect_pc : fetch_pc_q;
        w_issue      = redirect | ((32'(w_count) + 32'(req_valid_q)) < 32'(DEPTH));
        insn_valid   = (w_count != '0) & ~redirect;
        w_pop        = insn_valid & insn_ready;
        w_push       = req_valid_q & ~redirect;
        w_push_entry = '{pc: req_pc_q, insn: q_imem};

        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = w_issue;
        if (w_issue) begin
            fetch_pc_d = address_imem + 32'd1;
            req_pc_d   = address_imem;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= 32'h0;
            req_pc_q    <= 32'h0;
            req_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign w_head_entry = fetch_entry_t'(w_head);
    assign insn         = w_head_entry.insn;
    assign insn_pc      = w_head_entry.pc;

endmodule

`default_nettype wire
